// File: rtl/ofdm_pkg.sv
// Shared bin map, pilot LFSR and FSM definitions
// for the OFDM 16-QAM symbol scheduler.
package ofdm_pkg;

  localparam logic [1:0] BT_NULL  = 2'b00;
  localparam logic [1:0] BT_DATA  = 2'b01;
  localparam logic [1:0] BT_PILOT = 2'b10;

  localparam logic [5:0] NULL_LO = 6'd27;
  localparam logic [5:0] NULL_HI = 6'd37;

  localparam int          N_PILOT   = 4;
  localparam logic [23:0] PILOT_IDX = {6'd57, 6'd43, 6'd21, 6'd7};

  // x^7 + x^4 + 1 : feedback from bits 6 and 3
  localparam logic [6:0] LFSR_SEED = 7'h7F;
  localparam logic [6:0] LFSR_TAPS = 7'b100_1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
    logic [1:0] btype;
    logic       last;
  } sb_t;

  function automatic logic [1:0] bin_class(input logic [5:0] idx);
    logic [1:0] c;
    c = BT_DATA;
    for (int i = 0; i < N_PILOT; i++)
      if (idx == PILOT_IDX[i*6 +: 6]) c = BT_PILOT;
    if (idx == 6'd0 || (idx >= NULL_LO && idx <= NULL_HI))
      c = BT_NULL;
    return c;
  endfunction

endpackage

// File: rtl/ofdm_pilot_lfsr.sv
// Per-symbol pilot polarity generator.
// Reloaded at burst start, stepped once per symbol.
import ofdm_pkg::*;

module ofdm_pilot_lfsr (
  input  logic clk,
  input  logic res,
  input  logic load,
  input  logic step,
  output logic pol
);

  logic [6:0] r_lfsr;
  logic       w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clk or negedge res) begin
    if (!res)
      r_lfsr <= LFSR_SEED;
    else if (load)
      r_lfsr <= LFSR_SEED;
    else if (step)
      r_lfsr <= {r_lfsr[5:0], w_fb};
  end

  assign pol = r_lfsr[6];

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Walks 64-bin OFDM symbols, feeds data/pilot nibbles to the
// 16-QAM mapper and emits bin sideband aligned to its output.
import ofdm_pkg::*;

module qam_symbol_scheduler #(
  parameter int unsigned GAP_CYCLES   = 16,
  parameter logic [3:0]  PILOT_NIBBLE = 4'b0000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [7:0] n_sym,
  input  logic       src_valid,
  input  logic [3:0] src_data,
  output logic       src_ready,
  input  logic       map_ready,
  output logic       map_en,
  output logic       map_valid,
  output logic [3:0] map_data,
  output logic       bin_valid,
  output logic [5:0] bin_idx,
  output logic [1:0] bin_type,
  output logic       sym_last,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] GAP_LAST =
    16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e      r_state;
  logic [5:0]  r_bin;
  logic [7:0]  r_sym;
  logic [15:0] r_gap;
  logic        r_map_valid;
  logic [3:0]  r_map_data;
  sb_t         r_sb1;
  sb_t         r_sb2;

  logic [1:0]  w_type;
  logic        w_run;
  logic        w_issue;
  logic        w_last_bin;
  logic        w_accept;
  logic        w_pol;
  logic [3:0]  w_pilot;

  assign w_type     = bin_class(r_bin);
  assign w_run      = (r_state == ST_RUN);
  assign w_last_bin = (r_bin == 6'd63);
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_issue    = w_run && map_ready &&
                      (w_type != BT_DATA || src_valid);

  assign src_ready  = w_run && map_ready && (w_type == BT_DATA);

  ofdm_pilot_lfsr u_lfsr (
    .clk  (clk),
    .res  (res),
    .load (w_accept),
    .step (w_issue && w_last_bin),
    .pol  (w_pol)
  );

  assign w_pilot = w_pol ?
    {~PILOT_NIBBLE[3:2], PILOT_NIBBLE[1:0]} : PILOT_NIBBLE;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_sym   <= '0;
      r_gap   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin   <= '0;
            r_sym   <= n_sym;
            r_state <= (n_sym != 8'd0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_bin <= r_bin + 6'd1;
            if (w_last_bin) begin
              r_sym <= r_sym - 8'd1;
              r_gap <= '0;
              if (r_sym == 8'd1)
                r_state <= ST_DONE;
              else if (GAP_CYCLES == 0)
                r_state <= ST_RUN;
              else
                r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          r_gap <= r_gap + 16'd1;
          if (r_gap == GAP_LAST)
            r_state <= ST_RUN;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Null bins issue sideband only; the mapper sees no valid.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_map_valid <= 1'b0;
      r_map_data  <= '0;
    end else begin
      r_map_valid <= w_issue && (w_type != BT_NULL);
      r_map_data  <= '0;
      if (w_issue && w_type == BT_DATA)
        r_map_data <= src_data;
      else if (w_issue && w_type == BT_PILOT)
        r_map_data <= w_pilot;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sb1 <= '0;
      r_sb2 <= '0;
    end else begin
      r_sb1 <= '0;
      if (w_issue) begin
        r_sb1.valid <= 1'b1;
        r_sb1.idx   <= r_bin;
        r_sb1.btype <= w_type;
        r_sb1.last  <= w_last_bin;
      end
      r_sb2 <= r_sb1;
    end
  end

  assign map_valid = r_map_valid;
  assign map_en    = r_map_valid;
  assign map_data  = r_map_data;
  assign bin_valid = r_sb2.valid;
  assign bin_idx   = r_sb2.idx;
  assign bin_type  = r_sb2.btype;
  assign sym_last  = r_sb2.last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Self-checking bench: burst-level scoreboard of expected bins,
// nibbles and pilot polarity, checked on every cycle.
module tb_qam_symbol_scheduler;

  logic       clk;
  logic       res;
  logic       start;
  logic [7:0] n_sym;
  logic       src_valid;
  logic [3:0] src_data;
  logic       src_ready;
  logic       map_ready;
  logic       map_en;
  logic       map_valid;
  logic [3:0] map_data;
  logic       bin_valid;
  logic [5:0] bin_idx;
  logic [1:0] bin_type;
  logic       sym_last;
  logic       busy;
  logic       done;

  qam_symbol_scheduler #(
    .GAP_CYCLES  (16),
    .PILOT_NIBBLE(4'b0000)
  ) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .n_sym    (n_sym),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .map_ready(map_ready),
    .map_en   (map_en),
    .map_valid(map_valid),
    .map_data (map_data),
    .bin_valid(bin_valid),
    .bin_idx  (bin_idx),
    .bin_type (bin_type),
    .sym_last (sym_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] idx;
    logic [1:0] bt;
    logic       pol;
    logic       last_burst;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] nib_q[$];
  exp_t       e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_burst, bins_cnt, mv_cnt, done_cnt = 0, done_cyc, start_cyc;
  int last_cyc, last_idx, max_hole, gap_hole;
  logic [3:0] first_pilot, last_pilot;
  logic       pilot_seen;
  logic       prev_mv, prev_done;
  logic [3:0] prev_md;
  logic [3:0] exp_nib;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] cls(input int b);
    if (b == 0 || (b >= 27 && b <= 37)) return 2'b00;
    if (b == 7 || b == 21 || b == 43 || b == 57) return 2'b10;
    return 2'b01;
  endfunction

  // Expected bin sequence of one burst, with per-symbol polarity
  task automatic push_burst(input int n);
    logic [6:0] st;
    exp_t x;
    st = 7'h7F;
    for (int s = 0; s < n; s++) begin
      for (int b = 0; b < 64; b++) begin
        x.idx = 6'(b);
        x.bt = cls(b);
        x.pol = st[6];
        x.last_burst = (s == n - 1) && (b == 63);
        exp_q.push_back(x);
      end
      st = {st[5:0], st[6] ^ st[3]};
    end
  endtask

  always @(negedge clk) begin
    if (!res) begin
      prev_mv = 1'b0;
      prev_md = 4'h0;
      prev_done = 1'b0;
    end else begin
      check("map_en_eq_valid", 32'(map_en), 32'(map_valid));
      check("map_align", 32'(prev_mv),
            32'(bin_valid && bin_type != 2'b00));
      if (src_valid && src_ready) begin
        nib_q.push_back(src_data);
        hs_burst++;
      end
      if (map_valid) mv_cnt++;
      if (done && !prev_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bin_valid) begin
        bins_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_extra", 32'(bin_idx), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("bin_idx", 32'(bin_idx), 32'(e.idx));
          check("bin_type", 32'(bin_type), 32'(e.bt));
          check("sym_last", 32'(sym_last), 32'(e.idx == 6'd63));
          if (e.bt == 2'b01) begin
            exp_nib = (nib_q.size() > 0) ? nib_q.pop_front() : 4'hx;
            check("data_nib", 32'(prev_md), 32'(exp_nib));
          end else if (e.bt == 2'b10) begin
            check("pilot_nib", 32'(prev_md), e.pol ? 32'hC : 32'h0);
            if (!pilot_seen) first_pilot = prev_md;
            pilot_seen = 1'b1;
            last_pilot = prev_md;
          end
          if (e.last_burst)
            check("done_align", 32'(prev_done), 32'd1);
        end
        if (last_cyc >= 0) begin
          if (bin_idx == 6'd0 && last_idx == 63)
            gap_hole = cyc - last_cyc - 1;
          else if (cyc - last_cyc - 1 > max_hole)
            max_hole = cyc - last_cyc - 1;
        end
        last_cyc = cyc;
        last_idx = int'(bin_idx);
      end
      prev_mv = map_valid;
      prev_md = map_data;
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    src_data = 4'($urandom_range(0, 15));
  endtask

  task automatic do_start(input int n, input bit accept);
    start = 1'b1;
    n_sym = 8'(n);
    if (accept) begin
      push_burst(n);
      hs_burst = 0;
      bins_cnt = 0;
      mv_cnt = 0;
      last_cyc = -1;
      max_hole = 0;
      gap_hole = -1;
      pilot_seen = 1'b0;
      start_cyc = cyc;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) begin
      tick();
      if (rnd) begin
        src_valid = ($urandom_range(0, 9) < 7);
        map_ready = ($urandom_range(0, 9) < 8);
      end
    end
    check("done_once", 32'(done_cnt - d0), 32'd1);
    src_valid = 1'b1;
    map_ready = 1'b1;
    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_hs(input int target);
    int i;
    for (i = 0; i < 2000 && hs_burst != target; i++) tick();
    check("wait_hs", 32'(hs_burst), 32'(target));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    res = 1'b0;
    start = 1'b0;
    n_sym = 8'd0;
    src_valid = 1'b0;
    src_data = 4'h0;
    map_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", 32'({map_en, map_valid, map_data, bin_valid,
          bin_idx, bin_type, sym_last, busy, done, src_ready}), 32'd0);
    res = 1'b1;
    tick();

    // one symbol, no stalls
    src_valid = 1'b1;
    map_ready = 1'b1;
    do_start(1, 1'b1);
    wait_done(400, 1'b0);
    check("t1_nibbles", 32'(hs_burst), 32'd48);
    check("t1_bins", 32'(bins_cnt), 32'd64);
    check("t1_map_valid", 32'(mv_cnt), 32'd52);
    // measured to the edge that captures done
    check("t1_done_lat", 32'(done_cyc + 1 - start_cyc), 32'd66);
    check("t1_no_hole", 32'(max_hole), 32'd0);
    check("t1_first_pilot", 32'(first_pilot), 32'hC);

    // two symbols with cyclic-prefix gap
    do_start(2, 1'b1);
    wait_done(600, 1'b0);
    check("t2_gap", 32'(gap_hole), 32'd16);
    check("t2_bins", 32'(bins_cnt), 32'd128);
    check("t2_map_valid", 32'(mv_cnt), 32'd104);
    check("t2_first_pilot", 32'(first_pilot), 32'hC);

    // source drops at bin 10 (8 data bins precede it)
    do_start(1, 1'b1);
    wait_hs(8);
    src_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_src_ready", 32'(src_ready), 32'd1);
      tick();
    end
    src_valid = 1'b1;
    wait_done(400, 1'b0);
    check("t3_hole", 32'(max_hole), 32'd5);
    check("t3_nibbles", 32'(hs_burst), 32'd48);

    // mapper stalls at pilot bin 21; long burst exercises polarity
    do_start(10, 1'b1);
    wait_hs(19);
    map_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_src_ready", 32'(src_ready), 32'd0);
      tick();
    end
    map_ready = 1'b1;
    wait_done(2000, 1'b0);
    check("t4_hole", 32'(max_hole), 32'd3);
    check("t4_gap", 32'(gap_hole), 32'd16);
    check("t4_last_pilot", 32'(last_pilot), 32'h0);

    // empty burst
    do_start(0, 1'b1);
    wait_done(20, 1'b0);
    check("t5_done_lat", 32'(done_cyc + 1 - start_cyc), 32'd2);
    check("t5_nibbles", 32'(hs_burst), 32'd0);
    check("t5_bins", 32'(bins_cnt), 32'd0);

    // start while busy is ignored
    do_start(1, 1'b1);
    repeat (20) tick();
    do_start(3, 1'b0);
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd1);
    tick();
    wait_done(400, 1'b0);
    check("t5_ignored_bins", 32'(bins_cnt), 32'd64);
    repeat (5) tick();
    check("t5_idle", 32'(busy), 32'd0);

    // reset at bin 30 of symbol 2 (72 data bins before it)
    do_start(3, 1'b1);
    wait_hs(72);
    repeat (3) tick();
    res = 1'b0;
    #1;
    check("t6_async_outs", 32'({map_en, map_valid, map_data, bin_valid,
          bin_idx, bin_type, sym_last, busy, done, src_ready}), 32'd0);
    exp_q.delete();
    nib_q.delete();
    d0 = done_cnt;
    repeat (2) tick();
    res = 1'b1;
    repeat (5) tick();
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    do_start(1, 1'b1);
    wait_done(400, 1'b0);
    check("t6_restart_bins", 32'(bins_cnt), 32'd64);
    check("t6_restart_pilot", 32'(first_pilot), 32'hC);

    // randomized source and mapper stalls
    for (int k = 0; k < 6; k++) begin
      do_start(int'($urandom_range(1, 4)), 1'b1);
      wait_done(4000, 1'b1);
      check("rnd_nib_q", 32'(nib_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qam_symbol_scheduler.md
# qam_symbol_scheduler

Sequences one or more 64-bin OFDM symbols through the 16-QAM mapper. Classifies each subcarrier bin as data, pilot or null, and pulls 4-bit data nibbles from the upstream source only for data bins. Inserts scrambled pilot nibbles and flags null bins, then emits bin-aligned sideband data so the IFFT loader can place the mapper's I/Q output. Sits between the data ROM/source and the `qam` mapper.

## Interface
- `GAP_CYCLES`, 16: idle cycles inserted between consecutive symbols (cyclic-prefix slot); 0 = back-to-back.
- `PILOT_NIBBLE`, 4'b0000: base pilot nibble before polarity.
- `clk` in 1: single clock; all state on rising edge.
- `res` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; begins a burst when idle.
- `n_sym` in 8: symbols per burst, sampled on accepted `start`.
- `src_valid` in 1: upstream nibble valid.
- `src_data` in 4: upstream nibble.
- `src_ready` out 1: combinational; nibble consumed when `src_valid && src_ready`.
- `map_ready` in 1: mapper ready (mapper's `ready_out`).
- `map_en` out 1: mapper enable, registered.
- `map_valid` out 1: mapper input valid, registered.
- `map_data` out 4: mapper nibble, registered.
- `bin_valid` out 1: sideband valid, aligned to mapper output cycle.
- `bin_idx` out 6: bin index of the aligned bin.
- `bin_type` out 2: 00 null, 01 data, 10 pilot.
- `sym_last` out 1: aligned bin is bin 63.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst end.

## Operation
- FSM states: IDLE, RUN, GAP, DONE.
  - IDLE→RUN on `start` when `n_sym != 0`; IDLE→DONE when `n_sym == 0`.
  - RUN→GAP after bin 63 when symbols remain and `GAP_CYCLES > 0`.
  - RUN→RUN after bin 63 when symbols remain and `GAP_CYCLES == 0`.
  - RUN→DONE after bin 63 of the last symbol.
  - GAP→RUN when the gap counter reaches `GAP_CYCLES-1`.
  - DONE→IDLE unconditionally; `done` is high in DONE.
- `start` is ignored outside IDLE. `busy` = state != IDLE.
- Bin classes (fixed):
  - null: 0 and 27..37 (12 bins).
  - pilot: 7, 21, 43, 57.
  - data: all other bins (48).
- Issue condition in RUN: `map_ready && (bin_type != data || src_valid)`. On issue the bin counter (6-bit, wraps 63→0) advances.
- `src_ready` = RUN && `map_ready` && current bin is data.
- Data bin: `map_data` = `src_data`, `map_valid` = 1.
- Pilot bin: `map_data` = `PILOT_NIBBLE`, with bits [3:2] inverted when the symbol polarity bit is 1; `map_valid` = 1.
- Null bin: `map_valid` = 0; the sideband still issues with `bin_type` = 00, and downstream zero-fills the bin.
- Pilot polarity comes from a 7-bit LFSR, x^7+x^4+1, seeded 7'h7F on each accepted `start`. The LFSR output bit is the MSB; it advances once per symbol, after bin 63.
- `map_en` = `map_valid`.
- A stall (`map_ready` low or data bin without `src_valid`) holds the bin counter, the LFSR and the symbol counter. No bin is skipped or duplicated.
- Symbol counter: 8-bit down-counter loaded with `n_sym`.

## Timing
- Reset values: state IDLE; all outputs 0; `map_data` 0; `bin_idx` 0; LFSR 7'h7F; all counters 0.
- Reset mid-burst aborts immediately. No `done` pulse; after release the block sits in IDLE.
- Mapper inputs are registered: a bin issued in cycle t is presented in t+1.
- Mapper output appears in t+2. The sideband (`bin_valid`, `bin_idx`, `bin_type`, `sym_last`) is delayed to appear in t+2, aligned with the mapper's `valid_qam`.
- Unstalled throughput: one bin per cycle, 64 cycles per symbol plus `GAP_CYCLES` between symbols.
- `done` is asserted one cycle after the last bin issues and precedes that bin's sideband by one cycle.
- The sideband pipeline drains regardless of state.

## Structure
- Shared `ofdm_pkg`:
  - bin-type constants;
  - null-range bounds 27/37;
  - pilot index list;
  - LFSR seed and taps;
  - FSM state enum.
- Sub-module `ofdm_pilot_lfsr`: 7-bit LFSR with `load` and `step` enables and a one-bit polarity output.
- Bin classification is a combinational function in the package.

## Test plan
- `n_sym`=1, source always valid, `map_ready`=1:
  - exactly 48 nibbles consumed;
  - 64 `bin_valid` pulses with indices 0..63;
  - `map_valid` count 52;
  - `done` 66 cycles after `start`.
- `n_sym`=2, `GAP_CYCLES`=16:
  - 16-cycle hole between bin 63 and bin 0;
  - pilot bits [3:2] differ per LFSR (first symbol polarity 1 → pilot nibble 4'b1100).
- Source drops `src_valid` for 5 cycles at bin 10:
  - bin counter holds at 10;
  - `src_ready` high throughout;
  - no sideband gap in indices.
- `map_ready` low 3 cycles at pilot bin 21:
  - no issue and no LFSR step during the stall;
  - resumes at 21.
- `n_sym`=0 → `done` 2 cycles after `start`, no nibbles consumed. A `start` while busy is ignored.
- Assert `res` low at bin 30 of symbol 2:
  - all outputs 0 asynchronously;
  - IDLE after release;
  - new `start` restarts at bin 0 with LFSR 7'h7F.
